// File: rtl/unidade_controle_mc_pkg.sv
// Shared types for the multicycle MIPS control unit: state encoding, opcode/funct values and datapath mux encodings.
// ILLEGAL_TRAP_EN adds the TRAP state.
package uc_pkg;

  localparam int UC_STATE_W = 5;
  localparam int CNT_W      = $clog2(16);

  typedef enum logic [UC_STATE_W-1:0] {
    ST_FETCH      = 5'd0,
    ST_FETCH_WAIT = 5'd1,
    ST_IR_WRITE   = 5'd2,
    ST_DECODE     = 5'd3,
    ST_EXEC_R     = 5'd4,
    ST_WRITE_RD   = 5'd5,
    ST_ADDR       = 5'd6,
    ST_STORE      = 5'd7,
    ST_LOAD_RD    = 5'd8,
    ST_LOAD_WAIT  = 5'd9,
    ST_LOAD_MDR   = 5'd10,
    ST_LOAD_WB    = 5'd11,
    ST_BRANCH     = 5'd12,
    ST_JUMP       = 5'd13,
    ST_LUI        = 5'd14,
    ST_ADDI_EX    = 5'd15,
    ST_ADDI_WB    = 5'd16,
    ST_BREAK      = 5'd17
`ifdef ILLEGAL_TRAP_EN
    , ST_TRAP     = 5'd18
`endif
  } ucState_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_NOP   = 6'h00;
  localparam logic [5:0] FN_BREAK = 6'h0D;

  localparam logic [1:0] PC_ALU     = 2'b00;
  localparam logic [1:0] PC_ALUOUT  = 2'b01;
  localparam logic [1:0] PC_JUMP    = 2'b10;

  localparam logic [1:0] MR_ALUOUT  = 2'b00;
  localparam logic [1:0] MR_MDR     = 2'b01;
  localparam logic [1:0] MR_LUI     = 2'b10;

  localparam logic [1:0] BALU_B     = 2'b00;
  localparam logic [1:0] BALU_4     = 2'b01;
  localparam logic [1:0] BALU_IMM   = 2'b10;
  localparam logic [1:0] BALU_IMMSH = 2'b11;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_SUB    = 2'b01;
  localparam logic [1:0] ALU_FUNCT  = 2'b10;

  // Counter preload so that a wait state lasts exactly `lat` cycles.
  function automatic logic [CNT_W-1:0] waitInit(input int lat);
    return (lat > 0) ? CNT_W'(lat - 1) : '0;
  endfunction

endpackage

// File: rtl/uc_wait_counter.sv
// Memory wait down-counter shared by the fetch and load wait states.
// Load has priority over decrement; holds at zero.
module uc_wait_counter
  import uc_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] loadVal,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= loadVal;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/unidade_controle_mc.sv
// Multicycle MIPS control unit: Moore FSM, outputs decoded from state only; memory wait of MEM_LATENCY cycles.
// No handshake: instruction length is fixed per opcode. ILLEGAL_TRAP_EN makes unknown opcodes trap instead of acting as nop.
module unidade_controle_mc
  import uc_pkg::*;
#(
  parameter int MEM_LATENCY = 1,
  parameter int STATE_W     = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [5:0]         OPcode,
  input  logic [5:0]         funct,
  output logic               EscreveMem,
  output logic               EscrevePC,
  output logic               EscrevePCCond,
  output logic               BranchNE,
  output logic [1:0]         OrigPC,
  output logic               RegDst,
  output logic               EscreveReg,
  output logic [1:0]         MemparaReg,
  output logic               IouD,
  output logic               EscreveIR,
  output logic               EscreveMDR,
  output logic               EscreveAluOut,
  output logic               OrigAALU,
  output logic [1:0]         OrigBALU,
  output logic [1:0]         OpALU,
  output logic               Halt,
  output logic               Trap,
  output logic [STATE_W-1:0] State
);

  localparam logic [CNT_W-1:0] WAIT_INIT = waitInit(MEM_LATENCY);

  ucState_t state, nextState;
  logic     isBne, isLoad;
  logic     cntLoad, cntDec, cntZero;

  uc_wait_counter waitCnt (
    .clock   (clock),
    .reset   (reset),
    .load    (cntLoad),
    .loadVal (WAIT_INIT),
    .dec     (cntDec),
    .zero    (cntZero)
  );

  // The opcode is only trusted in DECODE; later states use these captured flags.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= ST_FETCH;
      isBne  <= 1'b0;
      isLoad <= 1'b0;
    end else begin
      state <= nextState;
      if (state == ST_DECODE) begin
        isBne  <= (OPcode == OP_BNE);
        isLoad <= (OPcode == OP_LW);
      end
    end
  end

  always_comb begin
    nextState = ST_FETCH;
    cntLoad   = 1'b0;
    cntDec    = 1'b0;
    case (state)
      ST_FETCH: begin
        if (MEM_LATENCY > 0) begin
          nextState = ST_FETCH_WAIT;
          cntLoad   = 1'b1;
        end else begin
          nextState = ST_IR_WRITE;
        end
      end
      ST_FETCH_WAIT: begin
        nextState = cntZero ? ST_IR_WRITE : ST_FETCH_WAIT;
        cntDec    = 1'b1;
      end
      ST_IR_WRITE: nextState = ST_DECODE;
      ST_DECODE: begin
        case (OPcode)
          OP_RTYPE: begin
            if (funct == FN_BREAK)    nextState = ST_BREAK;
            else if (funct == FN_NOP) nextState = ST_FETCH;
            else                      nextState = ST_EXEC_R;
          end
          OP_LW, OP_SW:   nextState = ST_ADDR;
          OP_BEQ, OP_BNE: nextState = ST_BRANCH;
          OP_J:           nextState = ST_JUMP;
          OP_LUI:         nextState = ST_LUI;
          OP_ADDI:        nextState = ST_ADDI_EX;
`ifdef ILLEGAL_TRAP_EN
          default:        nextState = ST_TRAP;
`else
          default:        nextState = ST_FETCH;
`endif
        endcase
      end
      ST_EXEC_R:  nextState = ST_WRITE_RD;
      ST_ADDR:    nextState = isLoad ? ST_LOAD_RD : ST_STORE;
      ST_LOAD_RD: begin
        if (MEM_LATENCY > 0) begin
          nextState = ST_LOAD_WAIT;
          cntLoad   = 1'b1;
        end else begin
          nextState = ST_LOAD_MDR;
        end
      end
      ST_LOAD_WAIT: begin
        nextState = cntZero ? ST_LOAD_MDR : ST_LOAD_WAIT;
        cntDec    = 1'b1;
      end
      ST_LOAD_MDR: nextState = ST_LOAD_WB;
      ST_ADDI_EX:  nextState = ST_ADDI_WB;
      ST_BREAK:    nextState = ST_BREAK;
`ifdef ILLEGAL_TRAP_EN
      ST_TRAP:     nextState = ST_TRAP;
`endif
      default:     nextState = ST_FETCH;
    endcase
  end

  always_comb begin
    EscreveMem    = 1'b0;
    EscrevePC     = 1'b0;
    EscrevePCCond = 1'b0;
    BranchNE      = 1'b0;
    OrigPC        = PC_ALU;
    RegDst        = 1'b0;
    EscreveReg    = 1'b0;
    MemparaReg    = MR_ALUOUT;
    IouD          = 1'b0;
    EscreveIR     = 1'b0;
    EscreveMDR    = 1'b0;
    EscreveAluOut = 1'b0;
    OrigAALU      = 1'b0;
    OrigBALU      = BALU_B;
    OpALU         = ALU_ADD;
    Halt          = 1'b0;
    case (state)
      ST_IR_WRITE: begin
        EscreveIR = 1'b1;
        EscrevePC = 1'b1;
        OrigBALU  = BALU_4;
      end
      ST_DECODE: begin
        OrigBALU      = BALU_IMMSH;
        EscreveAluOut = 1'b1;
      end
      ST_EXEC_R: begin
        OrigAALU      = 1'b1;
        OpALU         = ALU_FUNCT;
        EscreveAluOut = 1'b1;
      end
      ST_WRITE_RD: begin
        RegDst     = 1'b1;
        EscreveReg = 1'b1;
      end
      ST_ADDR, ST_ADDI_EX: begin
        OrigAALU      = 1'b1;
        OrigBALU      = BALU_IMM;
        EscreveAluOut = 1'b1;
      end
      ST_STORE: begin
        IouD       = 1'b1;
        EscreveMem = 1'b1;
      end
      ST_LOAD_RD, ST_LOAD_WAIT: IouD = 1'b1;
      ST_LOAD_MDR: begin
        IouD       = 1'b1;
        EscreveMDR = 1'b1;
      end
      ST_LOAD_WB: begin
        MemparaReg = MR_MDR;
        EscreveReg = 1'b1;
      end
      ST_BRANCH: begin
        OrigAALU      = 1'b1;
        OpALU         = ALU_SUB;
        EscrevePCCond = 1'b1;
        OrigPC        = PC_ALUOUT;
        BranchNE      = isBne;
      end
      ST_JUMP: begin
        EscrevePC = 1'b1;
        OrigPC    = PC_JUMP;
      end
      ST_LUI: begin
        MemparaReg = MR_LUI;
        EscreveReg = 1'b1;
      end
      ST_ADDI_WB: EscreveReg = 1'b1;
      ST_BREAK:   Halt = 1'b1;
      default: ;
    endcase
  end

`ifdef ILLEGAL_TRAP_EN
  assign Trap = (state == ST_TRAP);
`else
  assign Trap = 1'b0;
`endif

  assign State = STATE_W'(state);

endmodule

// File: tb/tb_unidade_controle_mc.sv
// Bench for unidade_controle_mc: two instances (latency 1 and 3), per-cycle expected output vectors from a scoreboard queue.
module tb_unidade_controle_mc;
  import uc_pkg::*;

  typedef struct packed {
    logic       mem, pc, pcCond, bne;
    logic [1:0] origPc;
    logic       regDst, wReg;
    logic [1:0] mpr;
    logic       iouD, ir, mdr, aluOut, origA;
    logic [1:0] origB, opAlu;
    logic       halt, trap;
    logic [4:0] st;
  } vec_t;

  logic       clock = 1'b0;
  logic       rstN [2];
  logic [5:0] OPcode, funct;

  logic       escreveMem [2], escrevePc [2], escrevePcCond [2], branchNe [2];
  logic       regDst [2], escreveReg [2], iouD [2], escreveIr [2], escreveMdr [2];
  logic       escreveAluOut [2], origAAlu [2], halt [2], trap [2];
  logic [1:0] origPc [2], memparaReg [2], origBAlu [2], opAlu [2];
  logic [4:0] stateDbg [2];

  int   nChecked = 0;
  int   nFail    = 0;
  vec_t sb[$];

  always #5 clock = ~clock;

  for (genvar g = 0; g < 2; g++) begin : gDut
    unidade_controle_mc #(.MEM_LATENCY(g == 0 ? 1 : 3), .STATE_W(5)) dut (
      .clock         (clock),
      .reset         (rstN[g]),
      .OPcode        (OPcode),
      .funct         (funct),
      .EscreveMem    (escreveMem[g]),
      .EscrevePC     (escrevePc[g]),
      .EscrevePCCond (escrevePcCond[g]),
      .BranchNE      (branchNe[g]),
      .OrigPC        (origPc[g]),
      .RegDst        (regDst[g]),
      .EscreveReg    (escreveReg[g]),
      .MemparaReg    (memparaReg[g]),
      .IouD          (iouD[g]),
      .EscreveIR     (escreveIr[g]),
      .EscreveMDR    (escreveMdr[g]),
      .EscreveAluOut (escreveAluOut[g]),
      .OrigAALU      (origAAlu[g]),
      .OrigBALU      (origBAlu[g]),
      .OpALU         (opAlu[g]),
      .Halt          (halt[g]),
      .Trap          (trap[g]),
      .State         (stateDbg[g])
    );
  end

  function automatic vec_t obsOf(input int d);
    return {escreveMem[d], escrevePc[d], escrevePcCond[d], branchNe[d], origPc[d],
            regDst[d], escreveReg[d], memparaReg[d], iouD[d], escreveIr[d], escreveMdr[d],
            escreveAluOut[d], origAAlu[d], origBAlu[d], opAlu[d], halt[d], trap[d], stateDbg[d]};
  endfunction

  // Expected Moore outputs written straight from the control table, using literal encodings.
  function automatic vec_t expVec(input ucState_t s, input bit bne);
    vec_t v = '0;
    v.st = s;
    case (s)
      ST_IR_WRITE:  begin v.ir = 1; v.pc = 1; v.origB = 2'b01; end
      ST_DECODE:    begin v.origB = 2'b11; v.aluOut = 1; end
      ST_EXEC_R:    begin v.origA = 1; v.opAlu = 2'b10; v.aluOut = 1; end
      ST_WRITE_RD:  begin v.regDst = 1; v.wReg = 1; end
      ST_ADDR:      begin v.origA = 1; v.origB = 2'b10; v.aluOut = 1; end
      ST_STORE:     begin v.iouD = 1; v.mem = 1; end
      ST_LOAD_RD:   v.iouD = 1;
      ST_LOAD_WAIT: v.iouD = 1;
      ST_LOAD_MDR:  begin v.iouD = 1; v.mdr = 1; end
      ST_LOAD_WB:   begin v.mpr = 2'b01; v.wReg = 1; end
      ST_BRANCH:    begin v.origA = 1; v.opAlu = 2'b01; v.pcCond = 1; v.origPc = 2'b01; v.bne = bne; end
      ST_JUMP:      begin v.pc = 1; v.origPc = 2'b10; end
      ST_LUI:       begin v.mpr = 2'b10; v.wReg = 1; end
      ST_ADDI_EX:   begin v.origA = 1; v.origB = 2'b10; v.aluOut = 1; end
      ST_ADDI_WB:   v.wReg = 1;
      ST_BREAK:     v.halt = 1;
`ifdef ILLEGAL_TRAP_EN
      ST_TRAP:      v.trap = 1;
`endif
      default: ;
    endcase
    return v;
  endfunction

  task automatic checkVal(input string tag, input vec_t got, input vec_t exp);
    nChecked++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic pushSt(input ucState_t s, input bit bne);
    sb.push_back(expVec(s, bne));
  endtask

  // Called at a negedge with the DUT in FETCH; returns at the negedge of the next FETCH
  // (or right after the abortAt-th comparison when abortAt > 0).
  task automatic runInstr(input int d, input logic [5:0] op, input logic [5:0] fn,
                          input string name, input int abortAt);
    int   lat = (d == 0) ? 1 : 3;
    int   n   = 0;
    vec_t e;
    OPcode = op;
    funct  = fn;
    pushSt(ST_FETCH, 0);
    repeat (lat) pushSt(ST_FETCH_WAIT, 0);
    pushSt(ST_IR_WRITE, 0);
    pushSt(ST_DECODE, 0);
    case (op)
      6'h00: begin
        if (fn == 6'h0D) pushSt(ST_BREAK, 0);
        else if (fn != 6'h00) begin pushSt(ST_EXEC_R, 0); pushSt(ST_WRITE_RD, 0); end
      end
      6'h23: begin
        pushSt(ST_ADDR, 0); pushSt(ST_LOAD_RD, 0);
        repeat (lat) pushSt(ST_LOAD_WAIT, 0);
        pushSt(ST_LOAD_MDR, 0); pushSt(ST_LOAD_WB, 0);
      end
      6'h2B: begin pushSt(ST_ADDR, 0); pushSt(ST_STORE, 0); end
      6'h04: pushSt(ST_BRANCH, 0);
      6'h05: pushSt(ST_BRANCH, 1);
      6'h02: pushSt(ST_JUMP, 0);
      6'h0F: pushSt(ST_LUI, 0);
      6'h08: begin pushSt(ST_ADDI_EX, 0); pushSt(ST_ADDI_WB, 0); end
`ifdef ILLEGAL_TRAP_EN
      default: pushSt(ST_TRAP, 0);
`else
      default: ;
`endif
    endcase
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checkVal($sformatf("%s_L%0d_c%0d", name, lat, n + 1), obsOf(d), e);
      n++;
      if (n == abortAt) break;
      @(negedge clock);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached with %0d compared", nChecked);
    $fatal(1, "watchdog");
  end

  initial begin
    rstN[0] = 1'b0;
    rstN[1] = 1'b0;
    OPcode  = 6'h00;
    funct   = 6'h00;
    repeat (3) @(negedge clock);
    checkVal("reset_L1", obsOf(0), expVec(ST_FETCH, 0));
    checkVal("reset_L3", obsOf(1), expVec(ST_FETCH, 0));

    // Latency 1 instance
    rstN[0] = 1'b1;
    runInstr(0, 6'h00, 6'h20, "add",  -1);
    runInstr(0, 6'h05, 6'h00, "bne",  -1);
    runInstr(0, 6'h04, 6'h00, "beq",  -1);
    runInstr(0, 6'h2B, 6'h00, "sw",   -1);
    runInstr(0, 6'h02, 6'h00, "j",    -1);
    runInstr(0, 6'h0F, 6'h00, "lui",  -1);
    runInstr(0, 6'h08, 6'h00, "addi", -1);
    runInstr(0, 6'h00, 6'h00, "nop",  -1);
    runInstr(0, 6'h23, 6'h00, "lw",   -1);
    runInstr(0, 6'h3F, 6'h00, "ill",  -1);
`ifdef ILLEGAL_TRAP_EN
    for (int i = 0; i < 6; i++) begin
      OPcode = 6'($urandom);
      checkVal("trap_sticky", obsOf(0), expVec(ST_TRAP, 0));
      @(negedge clock);
    end
`endif
    rstN[0] = 1'b0;
    #1 checkVal("rst_after_ill", obsOf(0), expVec(ST_FETCH, 0));
    @(negedge clock);
    rstN[0] = 1'b1;
    runInstr(0, 6'h00, 6'h0D, "brk", -1);
    for (int i = 0; i < 22; i++) begin
      OPcode = 6'($urandom);
      funct  = 6'($urandom);
      checkVal("brk_hold", obsOf(0), expVec(ST_BREAK, 0));
      @(negedge clock);
    end
    #2 rstN[0] = 1'b0;
    #1 checkVal("brk_async_rst", obsOf(0), expVec(ST_FETCH, 0));

    // Latency 3 instance
    @(negedge clock);
    rstN[1] = 1'b1;
    runInstr(1, 6'h23, 6'h00, "lw", -1);
    // 9th cycle of lw at latency 3 is the first LOAD_WAIT
    runInstr(1, 6'h23, 6'h00, "lw_abort", 9);
    #2 rstN[1] = 1'b0;
    #1 checkVal("lw_async_rst", obsOf(1), expVec(ST_FETCH, 0));
    sb.delete();
    @(negedge clock);
    rstN[1] = 1'b1;
    runInstr(1, 6'h23, 6'h00, "lw_after_rst", -1);
    runInstr(1, 6'h00, 6'h22, "sub", -1);
    runInstr(1, 6'h05, 6'h00, "bne", -1);
    runInstr(1, 6'h00, 6'h00, "nop", -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nChecked, nFail);
    $finish;
  end

endmodule
